// File: rtl/jump_addr_unit.sv
// Jump target builder: concatenates the PC region bits with the word-granular
// jump field and appends two zero bits so the target is always word-aligned.
// A registered copy is captured whenever in_valid is high.
module jump_addr_unit #(
    parameter int REL_W   = 26,
    parameter int UPPER_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REL_W-1:0]           jump_relative_addr,
    input  logic [UPPER_W-1:0]         pc_upper,
    input  logic                       in_valid,
    output logic [UPPER_W+REL_W+1:0]   jump_addr,
    output logic [UPPER_W+REL_W+1:0]   jump_addr_q,
    output logic                       out_valid
);

    localparam int ADDR_W = UPPER_W + REL_W + 2;

    logic [ADDR_W-1:0] jump_addr_d;
    logic [ADDR_W-1:0] jump_addr_r_q;
    logic              out_valid_d;
    logic              out_valid_q;

    // Pure bit placement: no carry path, so all-ones inputs cannot wrap.
    always_comb begin
        jump_addr = {pc_upper, jump_relative_addr, 2'b00};
    end

    // Next-state: load on in_valid, otherwise hold; valid mirrors in_valid.
    always_comb begin
        jump_addr_d = jump_addr_r_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            jump_addr_d = jump_addr;
        end
    end

    // Capture register; reset clears both target and valid without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_addr_r_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            jump_addr_r_q <= jump_addr_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign jump_addr_q = jump_addr_r_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_jump_addr_unit.sv
// Directed bench for jump_addr_unit: combinational target, capture pipeline,
// hold behaviour and asynchronous reset.
module tb_jump_addr_unit;

    logic        clk;
    logic        rst_n;
    logic [25:0] jump_relative_addr;
    logic [3:0]  pc_upper;
    logic        in_valid;
    logic [31:0] jump_addr;
    logic [31:0] jump_addr_q;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    jump_addr_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .jump_relative_addr (jump_relative_addr),
        .pc_upper           (pc_upper),
        .in_valid           (in_valid),
        .jump_addr          (jump_addr),
        .jump_addr_q        (jump_addr_q),
        .out_valid          (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a vector at the falling edge with in_valid high, check the
    // combinational target, then check the registered copy after the edge.
    task automatic cap(input string tag, input logic [25:0] rel, input logic [3:0] up,
                       input logic [31:0] exp);
        @(negedge clk);
        jump_relative_addr = rel;
        pc_upper           = up;
        in_valid           = 1'b1;
        #1;
        chk({tag, "_comb"}, jump_addr, exp);
        @(posedge clk);
        #1;
        chk({tag, "_q"}, jump_addr_q, exp);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst_n              = 1'b0;
        in_valid           = 1'b0;
        jump_relative_addr = 26'h0;
        pc_upper           = 4'h0;
        #2;
        chk("rst_q", jump_addr_q, 32'h0000_0000);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);

        // Combinational path keeps tracking while in reset.
        jump_relative_addr = 26'h000_0001;
        pc_upper           = 4'h0;
        in_valid           = 1'b1;
        #1;
        chk("rst_comb", jump_addr, 32'h0000_0004);
        @(posedge clk);
        #1;
        chk("rst_edge_q", jump_addr_q, 32'h0000_0000);
        chk("rst_edge_vld", {31'd0, out_valid}, 32'd0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Back-to-back captures with one-cycle latency.
        cap("v1", 26'h000_0001, 4'h0, 32'h0000_0004);
        cap("v2", 26'h000_0000, 4'hF, 32'hF000_0000);
        cap("v3", 26'h000_0001, 4'hF, 32'hF000_0004);
        cap("v4", 26'h2AA_AAAA, 4'hF, 32'hFAAA_AAA8);
        cap("v5", 26'h0CC_CCCC, 4'hF, 32'hF333_3330);
        cap("v6", 26'h3FF_FFFF, 4'hF, 32'hFFFF_FFFC);
        cap("v7", 26'h155_5555, 4'h5, 32'h5555_5554);

        // Drop in_valid and change inputs: register holds, valid falls.
        @(negedge clk);
        in_valid           = 1'b0;
        jump_relative_addr = 26'h123_4567;
        pc_upper           = 4'hA;
        #1;
        chk("hold_comb", jump_addr, 32'hA48D_159C);
        @(posedge clk);
        #1;
        chk("hold_q", jump_addr_q, 32'h5555_5554);
        chk("hold_vld", {31'd0, out_valid}, 32'd0);

        // Unknown inputs with in_valid low must not reach the register.
        @(negedge clk);
        jump_relative_addr = 'x;
        pc_upper           = 'x;
        @(posedge clk);
        #1;
        chk("x_hold_q", jump_addr_q, 32'h5555_5554);
        chk("x_hold_vld", {31'd0, out_valid}, 32'd0);

        // Capture, then assert reset between edges.
        cap("pre_rst", 26'h000_00FF, 4'h3, 32'h3000_03FC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", jump_addr_q, 32'h0000_0000);
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        jump_relative_addr = 26'h000_0010;
        pc_upper           = 4'h1;
        #1;
        chk("mid_rst_comb", jump_addr, 32'h1000_0040);
        @(posedge clk);
        #1;
        chk("mid_rst_edge_q", jump_addr_q, 32'h0000_0000);

        // Release with in_valid high: first edge after release captures.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_q", jump_addr_q, 32'h1000_0040);
        chk("post_rst_vld", {31'd0, out_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
